// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - RV64M multiply sequencer between the EXU and the shift-add multiplier
// Issues ops with valid/ready, holds the result until consumed, and reuses a one-entry result cache.
module mul_issue_ctrl #(
  parameter int TAG_W    = 5,
  parameter bit CACHE_EN = 1'b1,
  parameter int TIMEOUT  = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_word,
  input  logic [63:0]      in_src1,
  input  logic [63:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             timeout_err,
  output logic             m_valid,
  output logic             m_mulw,
  output logic [1:0]       m_signed,
  output logic [63:0]      m_multiplicand,
  output logic [63:0]      m_multiplier,
  input  logic             m_ready,
  input  logic             m_out_valid,
  input  logic [63:0]      m_result_hi,
  input  logic [63:0]      m_result_lo
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state, state_next;
  logic [1:0]         op_q;
  logic               word_q;
  logic [63:0]        src1_q, src2_q;
  logic [TAG_W-1:0]   tag_q;
  logic [1:0]         sgn_q;
  logic [63:0]        data_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;

  logic               c_valid;
  logic [63:0]        c_src1, c_src2, c_hi, c_lo;
  logic [1:0]         c_sgn;

  logic [1:0]         in_sgn;
  logic               hit;
  logic               accept;

  function automatic logic [1:0] sgn_of(input logic word, input logic [1:0] op);
    if (word) return 2'b11;
    case (op)
      2'b10:   return 2'b10;
      2'b11:   return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [63:0] select(input logic word, input logic [1:0] op,
                                         input logic [63:0] hi, input logic [63:0] lo);
    if (word) return {{32{lo[31]}}, lo[31:0]};
    if (op == 2'b00) return lo;
    return hi;
  endfunction

  assign in_sgn = sgn_of(in_word, in_op);
  assign accept = (state == S_IDLE) && in_valid && !flush;

  // The low product word is the same for every signedness, so MUL may reuse any entry.
  assign hit = CACHE_EN && c_valid && !in_word &&
               (in_src1 == c_src1) && (in_src2 == c_src2) &&
               ((in_op == 2'b00) || (in_sgn == c_sgn));

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    m_valid    = 1'b0;
    out_valid  = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (accept) state_next = hit ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        m_valid = !flush;
        if (flush)        state_next = S_IDLE;
        else if (m_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (m_out_valid) state_next = flush ? S_IDLE : S_DONE;
        else if (flush)  state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (m_out_valid) state_next = S_IDLE;
      end
      S_DONE: begin
        out_valid = !flush;
        if (flush || out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= 2'b00;
      word_q  <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      tag_q   <= '0;
      sgn_q   <= 2'b00;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      c_valid <= 1'b0;
      c_src1  <= '0;
      c_src2  <= '0;
      c_hi    <= '0;
      c_lo    <= '0;
      c_sgn   <= 2'b00;
    end else begin
      state <= state_next;

      if (accept) begin
        op_q   <= in_op;
        word_q <= in_word;
        src1_q <= in_src1;
        src2_q <= in_src2;
        tag_q  <= in_tag;
        sgn_q  <= in_sgn;
        if (hit) data_q <= select(1'b0, in_op, c_hi, c_lo);
      end

      if (state == S_WAIT) begin
        if (cnt_q != CNT_W'(TIMEOUT)) cnt_q <= cnt_q + 1'b1;
        if (cnt_q >= CNT_W'(TIMEOUT - 1)) err_q <= 1'b1;
      end else begin
        cnt_q <= '0;
      end

      if ((state == S_WAIT) && m_out_valid && !flush) begin
        data_q <= select(word_q, op_q, m_result_hi, m_result_lo);
        if (!word_q) begin
          c_valid <= 1'b1;
          c_src1  <= src1_q;
          c_src2  <= src2_q;
          c_sgn   <= sgn_q;
          c_hi    <= m_result_hi;
          c_lo    <= m_result_lo;
        end
      end

      if (state == S_DRAIN) c_valid <= 1'b0;
    end
  end

  assign out_data       = data_q;
  assign out_tag        = tag_q;
  assign timeout_err    = err_q;
  assign m_mulw         = word_q;
  assign m_signed       = sgn_q;
  assign m_multiplicand = src1_q;
  assign m_multiplier   = src2_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb/tb_mul_issue_ctrl.sv - directed vector bench for mul_issue_ctrl
module tb_mul_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic        in_word = 1'b0;
  logic [63:0] in_src1 = '0;
  logic [63:0] in_src2 = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [4:0]  out_tag;
  logic        busy;
  logic        timeout_err;
  logic        m_valid;
  logic        m_mulw;
  logic [1:0]  m_signed;
  logic [63:0] m_multiplicand;
  logic [63:0] m_multiplier;
  logic        m_ready = 1'b0;
  logic        m_out_valid = 1'b0;
  logic [63:0] m_result_hi = '0;
  logic [63:0] m_result_lo = '0;

  int total = 0;
  int bad = 0;

  mul_issue_ctrl #(.TAG_W(5), .CACHE_EN(1'b1), .TIMEOUT(80)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .busy(busy), .timeout_err(timeout_err),
    .m_valid(m_valid), .m_mulw(m_mulw), .m_signed(m_signed),
    .m_multiplicand(m_multiplicand), .m_multiplier(m_multiplier), .m_ready(m_ready),
    .m_out_valid(m_out_valid), .m_result_hi(m_result_hi), .m_result_lo(m_result_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic        word;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [4:0]  tag;
    int          rdy_dly;
    int          lat;
    int          hold;
    logic        exp_issue;
    logic [1:0]  exp_sgn;
    logic        exp_mulw;
    logic [63:0] exp_data;
  } vec_t;

  localparam logic [63:0] A = 64'h0000_0001_0000_0001;
  localparam logic [63:0] B = 64'h0000_0001_0000_0003;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mul_model(input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] sgn);
    logic [127:0] xa, xb;
    xa = sgn[1] ? {{64{a[63]}}, a} : {64'b0, a};
    xb = sgn[0] ? {{64{b[63]}}, b} : {64'b0, b};
    return xa * xb;
  endfunction

  task automatic accept_op(input logic [1:0] op, input logic word, input logic [63:0] s1,
                           input logic [63:0] s2, input logic [4:0] tag);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_word = word; in_src1 = s1; in_src2 = s2; in_tag = tag;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Plays the multiplier and the EXU consumer for one op and reports what was seen.
  task automatic run_vec(input vec_t v, input string nm);
    logic issued, hs, done, stable;
    int mv_cycles, rc, cd, held, valid_at, res_at;
    logic [1:0] sgn;
    logic mw;
    logic [63:0] data, op1, op2;
    logic [4:0] tag;
    logic [127:0] p;
    issued = 0; hs = 0; done = 0; stable = 1; mv_cycles = 0; rc = 0; cd = 0; held = 0;
    valid_at = -1; res_at = -1; sgn = 0; mw = 0; data = '0; tag = '0; p = '0; op1 = '0; op2 = '0;
    accept_op(v.op, v.word, v.s1, v.s2, v.tag);
    for (int n = 1; n <= 300 && !done; n++) begin
      @(negedge clk);
      m_out_valid = 1'b0;
      if (m_ready) begin
        m_ready = 1'b0; hs = 1; cd = v.lat;
      end
      if (hs) begin
        if (cd == 0) begin
          m_out_valid = 1'b1; m_result_hi = p[127:64]; m_result_lo = p[63:0];
          hs = 0; res_at = n;
        end else cd--;
      end
      if (m_valid) begin
        issued = 1; mv_cycles++; sgn = m_signed; mw = m_mulw;
        op1 = m_multiplicand; op2 = m_multiplier;
        p = mul_model(m_multiplicand, m_multiplier, m_signed);
        if (rc == v.rdy_dly) m_ready = 1'b1; else rc++;
      end
      if (out_valid) begin
        if (valid_at < 0) begin
          valid_at = n; data = out_data; tag = out_tag;
        end else if (out_data !== data || out_tag !== tag) stable = 0;
        if (held == v.hold) begin
          out_ready = 1'b1; done = 1;
        end else held++;
      end
    end
    if (done) begin
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
    chk({nm, " issued"}, 64'(issued), 64'(v.exp_issue));
    if (v.exp_issue) begin
      chk({nm, " m_signed"}, 64'(sgn), 64'(v.exp_sgn));
      chk({nm, " m_mulw"}, 64'(mw), 64'(v.exp_mulw));
      chk({nm, " operands"}, {op1 ^ v.s1} | {op2 ^ v.s2}, 64'd0);
      chk({nm, " m_valid cycles"}, 64'(mv_cycles), 64'(v.rdy_dly + 1));
      chk({nm, " latency"}, 64'(valid_at), 64'(res_at + 1));
    end else begin
      chk({nm, " hit latency"}, 64'(valid_at), 64'd1);
    end
    chk({nm, " out_data"}, data, v.exp_data);
    chk({nm, " out_tag"}, 64'(tag), 64'(v.tag));
    chk({nm, " held stable"}, 64'(stable), 64'd1);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{2'b00, 1'b0, 64'd3, 64'd5, 5'd7, 0, 2, 0, 1'b1, 2'b11, 1'b0, 64'd15};
    vecs[1] = '{2'b01, 1'b0, ONES, ONES, 5'd1, 3, 1, 5, 1'b1, 2'b11, 1'b0, 64'd0};
    vecs[2] = '{2'b11, 1'b0, ONES, ONES, 5'd2, 0, 0, 0, 1'b1, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[3] = '{2'b10, 1'b0, ONES, 64'd2, 5'd3, 1, 3, 0, 1'b1, 2'b10, 1'b0, ONES};
    vecs[4] = '{2'b00, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd4, 0, 1, 1, 1'b1, 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[5] = '{2'b00, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd20, 0, 0, 0, 1'b1, 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[6] = '{2'b01, 1'b0, A, B, 5'd5, 0, 2, 0, 1'b1, 2'b11, 1'b0, 64'd1};
    vecs[7] = '{2'b00, 1'b0, A, B, 5'd6, 0, 0, 2, 1'b0, 2'b11, 1'b0, 64'h0000_0004_0000_0003};
    vecs[8] = '{2'b11, 1'b0, A, B, 5'd8, 0, 1, 0, 1'b1, 2'b00, 1'b0, 64'd1};
    vecs[9] = '{2'b01, 1'b0, A, B, 5'd9, 2, 0, 0, 1'b1, 2'b11, 1'b0, 64'd1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset outs", {out_valid, busy, timeout_err, m_valid, m_mulw, m_signed}, 64'd0);
    chk("reset data", out_data | m_multiplicand | m_multiplier | 64'(out_tag), 64'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Flush in WAIT: drain the pending pulse, then the cache must be empty.
    accept_op(2'b00, 1'b0, 64'd3, 64'd5, 5'd10);
    @(negedge clk); m_ready = 1'b1;
    @(negedge clk); m_ready = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drain busy %0d", i), 64'(busy), 64'd1);
      chk($sformatf("drain out_valid %0d", i), 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    m_out_valid = 1'b1; m_result_hi = 64'd99; m_result_lo = 64'd98;
    @(negedge clk); m_out_valid = 1'b0;
    chk("drain exit busy", 64'(busy), 64'd0);
    chk("drain exit out_valid", 64'(out_valid), 64'd0);
    run_vec('{2'b00, 1'b0, A, B, 5'd11, 0, 1, 0, 1'b1, 2'b11, 1'b0, 64'h0000_0004_0000_0003},
            "post-drain");

    // Flush while a hit result sits in DONE.
    accept_op(2'b00, 1'b0, A, B, 5'd12);
    @(negedge clk);
    chk("done out_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    #1 chk("done flush gates out_valid", 64'(out_valid), 64'd0);
    @(negedge clk); flush = 1'b0;
    chk("done flush busy", 64'(busy), 64'd0);
    chk("done flush out_valid", 64'(out_valid), 64'd0);

    // Multiplier never answers: timeout_err must rise and stick.
    accept_op(2'b00, 1'b0, 64'd7, 64'd9, 5'd13);
    @(negedge clk); m_ready = 1'b1;
    @(negedge clk); m_ready = 1'b0;
    repeat (40) @(negedge clk);
    chk("timeout early", 64'(timeout_err), 64'd0);
    repeat (50) @(negedge clk);
    chk("timeout set", 64'(timeout_err), 64'd1);
    chk("timeout still waiting", 64'(busy), 64'd1);
    m_out_valid = 1'b1; m_result_hi = 64'd0; m_result_lo = 64'd63;
    @(negedge clk); m_out_valid = 1'b0;
    chk("timeout late result", out_data, 64'd63);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk("timeout sticky", 64'(timeout_err), 64'd1);

    // Reset while waiting; a late pulse must be ignored.
    accept_op(2'b11, 1'b0, 64'd7, 64'd9, 5'd14);
    @(negedge clk); m_ready = 1'b1;
    @(negedge clk); m_ready = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst state", {busy, timeout_err, m_signed}, 64'd0);
    m_out_valid = 1'b1; m_result_lo = 64'd5;
    @(negedge clk); m_out_valid = 1'b0;
    chk("midrst late pulse", {out_valid, busy, in_ready}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
